// File: rtl/fifo_pkg.sv
// Shared helpers for the level-reporting synchronous FIFO: counter sizing and
// pointer wrap for arbitrary (non power-of-2) depths.
package fifo_pkg;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers wrap explicitly at depth-1 so any depth works without masking
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        int unsigned nxt;
        if (ptr == depth - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_sync_level_if.sv
// Handshake/status bundle between a FIFO user (master) and fifo_sync_level (slave).
interface fifo_sync_level_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = fifo_cnt_w(4)
);
    logic             flush;
    logic             write;
    logic [WIDTH-1:0] wdata;
    logic             read;
    logic [WIDTH-1:0] rdata;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, write, wdata, read,
        input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, write, wdata, read,
        output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, not reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/fifo_sync_level.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, optional
// first-word-fall-through, flush and sticky overflow/underflow flags.
module fifo_sync_level
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input logic              clk,
    input logic              reset,
    fifo_sync_level_if.slave bus
);
    localparam int CW = fifo_cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "fifo_sync_level: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "fifo_sync_level: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
        $fatal(1, "fifo_sync_level: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_r;
    logic             empty_r;
    logic             almost_full_r;
    logic             almost_empty_r;
    logic             overflow_r;
    logic             underflow_r;
    logic [WIDTH-1:0] rdata_r;
    logic [WIDTH-1:0] ram_rdata_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic [CW-1:0]    count_nxt_s;

    // Acceptance uses the registered flags only, so a full FIFO never takes a write
    always_comb begin
        wr_acc_s    = 1'b0;
        rd_acc_s    = 1'b0;
        count_nxt_s = count_r;
        if (!bus.flush) begin
            wr_acc_s = bus.write & ~full_r;
            rd_acc_s = bus.read & ~empty_r;
        end else begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end
        count_nxt_s = count_r + CW'(wr_acc_s) - CW'(rd_acc_s);
    end

    // Pointer, occupancy, flag and read-data state
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
            rdata_r        <= {WIDTH{1'b0}};
        end else if (bus.flush) begin
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= PW'(ptr_inc(32'(wr_ptr_r), 32'(DEPTH)));
            end
            if (rd_acc_s) begin
                rd_ptr_r <= PW'(ptr_inc(32'(rd_ptr_r), 32'(DEPTH)));
            end
            count_r        <= count_nxt_s;
            full_r         <= (count_nxt_s == CW'(DEPTH));
            empty_r        <= (count_nxt_s == {CW{1'b0}});
            almost_full_r  <= (count_nxt_s >= CW'(AF_LEVEL));
            almost_empty_r <= (count_nxt_s <= CW'(AE_LEVEL));
            if (bus.write && full_r) begin
                overflow_r <= 1'b1;
            end
            if (bus.read && empty_r) begin
                underflow_r <= 1'b1;
            end
            if ((FWFT == 0) && rd_acc_s) begin
                rdata_r <= ram_rdata_s;
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (bus.wdata),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

    // In FWFT mode the head word is shown directly; forced to zero while empty
    assign bus.rdata        = (FWFT != 0) ? (empty_r ? {WIDTH{1'b0}} : ram_rdata_s) : rdata_r;
    assign bus.count        = count_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule
